// File: rtl/service_pkg.sv
// Shared types, widths and per-service lookup tables for the job scheduler.
package service_pkg;

  localparam int unsigned SVC_W    = 6;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned COST_W   = 8;
  localparam int unsigned FEE_W    = 4;
  localparam int unsigned TIME_W   = 6;
  localparam int unsigned REFUND_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_SERVE  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Base cost of service 1..6 (0 for no service).
  function automatic logic [COST_W-1:0] base_cost(input logic [IDX_W-1:0] svc);
    case (svc)
      3'd1, 3'd2: base_cost = 8'd20;
      3'd3, 3'd4: base_cost = 8'd30;
      3'd5, 3'd6: base_cost = 8'd10;
      default:    base_cost = '0;
    endcase
  endfunction

  // Priority surcharge of service 1..6.
  function automatic logic [FEE_W-1:0] prio_fee(input logic [IDX_W-1:0] svc);
    case (svc)
      3'd1, 3'd2: prio_fee = 4'd2;
      3'd3, 3'd4: prio_fee = 4'd3;
      3'd5, 3'd6: prio_fee = 4'd1;
      default:    prio_fee = '0;
    endcase
  endfunction

  // Refund granted when service 1..6 overruns its estimate.
  function automatic logic [REFUND_W-1:0] overrun_refund(input logic [IDX_W-1:0] svc);
    case (svc)
      3'd1, 3'd2: overrun_refund = 7'd10;
      3'd3, 3'd4: overrun_refund = 7'd15;
      3'd5, 3'd6: overrun_refund = 7'd5;
      default:    overrun_refund = '0;
    endcase
  endfunction

  // Estimated time of service 1..6; priority jobs get the faster table.
  function automatic logic [TIME_W-1:0] est_time(input logic [IDX_W-1:0] svc,
                                                 input logic             pri);
    case (svc)
      3'd1, 3'd2: est_time = pri ? 6'd4 : 6'd5;
      3'd3, 3'd4: est_time = pri ? 6'd6 : 6'd7;
      3'd5, 3'd6: est_time = pri ? 6'd2 : 6'd3;
      default:    est_time = '0;
    endcase
  endfunction

  // Service number (1..6) of the lowest set mask bit, 0 if the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_svc(input logic [SVC_W-1:0] mask);
    lowest_svc = '0;
    for (int i = SVC_W - 1; i >= 0; i--) begin
      if (mask[i]) lowest_svc = IDX_W'(i + 1);
    end
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Small synchronous FIFO holding pending job service masks.
module job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop & ~o_empty_c;
  assign o_data_c  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/service_job_scheduler.sv
// Two-queue job scheduler: serves one job's services in order and reports totals.
module service_job_scheduler
  import service_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned ELAPSED_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [SVC_W-1:0]    req_services,
  input  logic                req_priority,
  output logic                req_ready,
  input  logic                tick,
  input  logic                svc_done,
  output logic                busy,
  output logic [IDX_W-1:0]    cur_service,
  output logic                done,
  output logic                done_priority,
  output logic [COST_W-1:0]   done_cost,
  output logic [FEE_W-1:0]    done_fee,
  output logic [TIME_W-1:0]   done_time,
  output logic [REFUND_W-1:0] done_refund
);

  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CMP_W = ELAPSED_W + TIME_W;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_busy;
  logic [SC_W-1:0]     r_starve;
  logic [SVC_W-1:0]    r_mask;
  logic                r_is_pri;
  logic [ELAPSED_W-1:0] r_elapsed;
  logic [IDX_W-1:0]    r_cur_service;
  logic [COST_W-1:0]   r_acc_cost;
  logic [FEE_W-1:0]    r_acc_fee;
  logic [TIME_W-1:0]   r_acc_time;
  logic [REFUND_W-1:0] r_acc_refund;
  logic                r_done;
  logic                r_done_priority;
  logic [COST_W-1:0]   r_done_cost;
  logic [FEE_W-1:0]    r_done_fee;
  logic [TIME_W-1:0]   r_done_time;
  logic [REFUND_W-1:0] r_done_refund;

  logic                w_pri_full, w_pri_empty, w_nrm_full, w_nrm_empty;
  logic [SVC_W-1:0]    w_pri_data, w_nrm_data;
  logic                w_accept, w_push_pri, w_push_nrm;
  logic                w_pick_pri, w_pick_nrm, w_pop_pri, w_pop_nrm;
  logic [IDX_W-1:0]    w_low;
  logic [COST_W-1:0]   w_cost;
  logic [FEE_W-1:0]    w_fee;
  logic [TIME_W-1:0]   w_est;
  logic [REFUND_W-1:0] w_refund;
  logic                w_overrun;

  // Request acceptance; empty-mask requests are accepted but never queued.
  assign req_ready  = req_priority ? ~w_pri_full : ~w_nrm_full;
  assign w_accept   = req_valid & req_ready;
  assign w_push_pri = w_accept & req_priority & (|req_services);
  assign w_push_nrm = w_accept & ~req_priority & (|req_services);

  // Arbitration: priority first unless the normal queue has waited too long.
  assign w_pick_nrm = ~w_nrm_empty & (w_pri_empty | (r_starve == SC_W'(STARVE_LIMIT)));
  assign w_pick_pri = ~w_pri_empty & ~w_pick_nrm;

  // Per-service lookups for the service currently being served.
  assign w_low     = lowest_svc(r_mask);
  assign w_cost    = base_cost(r_cur_service);
  assign w_fee     = r_is_pri ? prio_fee(r_cur_service) : '0;
  assign w_est     = est_time(r_cur_service, r_is_pri);
  assign w_refund  = overrun_refund(r_cur_service);
  assign w_overrun = CMP_W'(r_elapsed) > CMP_W'(w_est);

  job_fifo #(.DEPTH(DEPTH), .WIDTH(SVC_W)) u_pri_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_pri),
    .i_data    (req_services),
    .i_pop     (w_pop_pri),
    .o_data_c  (w_pri_data),
    .o_full_c  (w_pri_full),
    .o_empty_c (w_pri_empty)
  );

  job_fifo #(.DEPTH(DEPTH), .WIDTH(SVC_W)) u_nrm_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_nrm),
    .i_data    (req_services),
    .i_pop     (w_pop_nrm),
    .o_data_c  (w_nrm_data),
    .o_full_c  (w_nrm_full),
    .o_empty_c (w_nrm_empty)
  );

  // State register; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and queue pop decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_pri   = 1'b0;
    w_pop_nrm   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop_pri = w_pick_pri;
        w_pop_nrm = w_pick_nrm;
        if (w_pick_pri || w_pick_nrm) w_state_nxt = ST_SCAN;
      end
      ST_SCAN:   w_state_nxt = (r_mask == '0) ? ST_REPORT : ST_SERVE;
      ST_SERVE:  if (svc_done) w_state_nxt = ST_SCAN;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Starvation counter: consecutive priority pops while normal work waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_nrm_empty || w_pop_nrm) begin
      r_starve <= '0;
    end else if (w_pop_pri) begin
      r_starve <= r_starve + SC_W'(1);
    end
  end

  // Job datapath: load, per-service timing, accumulation and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask          <= '0;
      r_is_pri        <= 1'b0;
      r_elapsed       <= '0;
      r_cur_service   <= '0;
      r_acc_cost      <= '0;
      r_acc_fee       <= '0;
      r_acc_time      <= '0;
      r_acc_refund    <= '0;
      r_done          <= 1'b0;
      r_done_priority <= 1'b0;
      r_done_cost     <= '0;
      r_done_fee      <= '0;
      r_done_time     <= '0;
      r_done_refund   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop_pri || w_pop_nrm) begin
            r_mask       <= w_pop_pri ? w_pri_data : w_nrm_data;
            r_is_pri     <= w_pop_pri;
            r_acc_cost   <= '0;
            r_acc_fee    <= '0;
            r_acc_time   <= '0;
            r_acc_refund <= '0;
          end
        end
        ST_SCAN: begin
          if (r_mask != '0) begin
            r_cur_service <= w_low;
            r_mask        <= r_mask & (r_mask - SVC_W'(1));
            r_elapsed     <= '0;
          end else begin
            r_done          <= 1'b1;
            r_done_priority <= r_is_pri;
            r_done_cost     <= r_acc_cost;
            r_done_fee      <= r_acc_fee;
            r_done_time     <= r_acc_time;
            r_done_refund   <= r_acc_refund;
          end
        end
        ST_SERVE: begin
          if (svc_done) begin
            r_acc_cost    <= r_acc_cost + w_cost + COST_W'(w_fee);
            r_acc_fee     <= r_acc_fee + w_fee;
            r_acc_time    <= r_acc_time + w_est;
            r_acc_refund  <= r_acc_refund + (w_overrun ? w_refund : '0);
            r_cur_service <= '0;
          end else if (tick && (r_elapsed != {ELAPSED_W{1'b1}})) begin
            r_elapsed <= r_elapsed + ELAPSED_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign cur_service   = r_cur_service;
  assign done          = r_done;
  assign done_priority = r_done_priority;
  assign done_cost     = r_done_cost;
  assign done_fee      = r_done_fee;
  assign done_time     = r_done_time;
  assign done_refund   = r_done_refund;

endmodule
